// File: rtl/apb_pkg.sv
// Shared types and constants for the APB arbiter slice.
// Owner and FSM encodings used by apb_arbiter and apb_arb_pick.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } apb_state_t;

  typedef enum logic {
    OWN_FETCH = 1'b0,
    OWN_DATA  = 1'b1
  } apb_owner_t;

  localparam logic [3:0]  STB_ALL   = 4'b1111;
  localparam logic [31:0] UART_ADDR = 32'h400;

endpackage

// File: rtl/apb_arb_pick.sv
// Grant logic for the fetch/data APB arbiter.
// APB_ARB_RR_EN selects round-robin; otherwise data beats fetch.
module apb_arb_pick
  import apb_pkg::*;
(
  input  logic       pclk,
  input  logic       rst,
  input  logic       f_req,
  input  logic       d_req,
  input  logic       take,
  output apb_owner_t win
);

`ifdef APB_ARB_RR_EN
  apb_owner_t ptr;

  // On a tie the pointer decides; a lone request always wins
  always_comb begin
    win = OWN_DATA;
    if (f_req && d_req)
      win = ptr;
    else if (f_req)
      win = OWN_FETCH;
  end

  // Pointer favours whoever was not just served
  always_ff @(posedge pclk) begin
    if (rst)
      ptr <= OWN_DATA;
    else if (take)
      ptr <= (win == OWN_DATA) ? OWN_FETCH : OWN_DATA;
  end
`else
  logic unused;
  assign unused = ^{pclk, rst, take};

  // Fixed priority: fetch only wins when data is idle
  always_comb begin
    win = OWN_DATA;
    if (f_req && !d_req)
      win = OWN_FETCH;
  end
`endif

endmodule

// File: rtl/apb_arbiter.sv
// Two-requester APB master: fetch and load/store share one bus.
// Build option APB_ARB_RR_EN enables round-robin grant.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  pclk,
  input  logic                  rst,
  input  logic                  f_req,
  input  logic [ADDR_WIDTH-1:0] f_addr,
  output logic [DATA_WIDTH-1:0] f_rdata,
  output logic                  f_done,
  output logic                  f_err,
  input  logic                  d_req,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic                  d_write,
  input  logic [3:0]            d_stb,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_done,
  output logic                  d_err,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic [DATA_WIDTH-1:0] pdata,
  output logic                  pwrite,
  output logic [3:0]            pstb,
  output logic                  psel,
  output logic                  penable,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready,
  input  logic                  perr
);

  apb_state_t state, nxt;
  apb_owner_t own, win;
  logic       take;

  assign take = (state == IDLE) && (f_req || d_req);

  apb_arb_pick u_pick (
    .pclk  (pclk),
    .rst   (rst),
    .f_req (f_req),
    .d_req (d_req),
    .take  (take),
    .win   (win)
  );

  // State register
  always_ff @(posedge pclk) begin
    if (rst)
      state <= IDLE;
    else
      state <= nxt;
  end

  // Next-state: ACCESS waits as long as the slave stalls
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (f_req || d_req) nxt = SETUP;
      SETUP:   nxt = ACCESS;
      ACCESS:  if (pready) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Registered bus and requester outputs
  always_ff @(posedge pclk) begin
    if (rst) begin
      own     <= OWN_DATA;
      paddr   <= '0;
      pdata   <= '0;
      pwrite  <= 1'b0;
      pstb    <= '0;
      psel    <= 1'b0;
      penable <= 1'b0;
      f_rdata <= '0;
      f_err   <= 1'b0;
      f_done  <= 1'b0;
      d_rdata <= '0;
      d_err   <= 1'b0;
      d_done  <= 1'b0;
    end else begin
      f_done <= 1'b0;
      d_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (take) begin
            own  <= win;
            psel <= 1'b1;
            if (win == OWN_DATA) begin
              paddr  <= d_addr;
              pdata  <= d_wdata;
              pwrite <= d_write;
              pstb   <= d_stb;
            end else begin
              paddr  <= f_addr;
              pdata  <= '0;
              pwrite <= 1'b0;
              pstb   <= STB_ALL;
            end
          end
        end
        SETUP: penable <= 1'b1;
        ACCESS: begin
          if (pready) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            if (own == OWN_DATA) begin
              d_rdata <= prdata;
              d_err   <= perr;
              d_done  <= 1'b1;
            end else begin
              f_rdata <= prdata;
              f_err   <= perr;
              f_done  <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Self-checking bench for apb_arbiter with a transaction-level model.
// Honors APB_ARB_RR_EN to pick the expected grant order.
module tb_apb_arbiter;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic [31:0] f_rdata;
  logic        f_done, f_err;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic        d_write = 1'b0;
  logic [3:0]  d_stb = '0;
  logic [31:0] d_rdata;
  logic        d_done, d_err;
  logic [31:0] paddr, pdata;
  logic        pwrite;
  logic [3:0]  pstb;
  logic        psel, penable;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0;
  logic        perr = 1'b0;

  int tot = 0;
  int bad = 0;

  bit          last_data = 1'b0;
  logic [31:0] mf_rd = '0;
  logic [31:0] md_rd = '0;
  logic        mf_err = 1'b0;
  logic        md_err = 1'b0;

  apb_arbiter dut (
    .pclk    (pclk),
    .rst     (rst),
    .f_req   (f_req),
    .f_addr  (f_addr),
    .f_rdata (f_rdata),
    .f_done  (f_done),
    .f_err   (f_err),
    .d_req   (d_req),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_write (d_write),
    .d_stb   (d_stb),
    .d_rdata (d_rdata),
    .d_done  (d_done),
    .d_err   (d_err),
    .paddr   (paddr),
    .pdata   (pdata),
    .pwrite  (pwrite),
    .pstb    (pstb),
    .psel    (psel),
    .penable (penable),
    .prdata  (prdata),
    .pready  (pready),
    .perr    (perr)
  );

  always #5 pclk = ~pclk;

  task automatic step;
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tot++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus_idle(input string tag);
    chk({tag, "_psel"}, psel, 0);
    chk({tag, "_penable"}, penable, 0);
    chk({tag, "_fdone"}, f_done, 0);
    chk({tag, "_ddone"}, d_done, 0);
  endtask

  // One full transfer, starting in an IDLE cycle and ending in the next
  task automatic xfer(input bit fr, input bit dr,
                      input logic [31:0] fa, input logic [31:0] da,
                      input logic [31:0] wd, input bit dw,
                      input logic [3:0] ds, input int waits,
                      input logic [31:0] rd, input bit er,
                      input bit ew, input bit keep);
    bit          wd_;
    logic [31:0] ea, ed;
    logic        ewr;
    logic [3:0]  es;
`ifdef APB_ARB_RR_EN
    if (fr && dr) wd_ = !last_data;
    else wd_ = dr;
`else
    wd_ = dr;
`endif
    last_data = wd_;
    ea  = wd_ ? da : fa;
    ed  = wd_ ? wd : 32'h0;
    ewr = wd_ ? dw : 1'b0;
    es  = wd_ ? ds : 4'hF;
    f_req = fr; d_req = dr;
    f_addr = fa; d_addr = da;
    d_wdata = wd; d_write = dw; d_stb = ds;
    step;
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_paddr", paddr, ea);
    chk("setup_pdata", pdata, ed);
    chk("setup_pwrite", pwrite, ewr);
    chk("setup_pstb", pstb, es);
    chk("setup_fdone", f_done, 0);
    chk("setup_ddone", d_done, 0);
    d_addr = da ^ 32'hC0;
    f_addr = ~fa;
    d_wdata = ~wd;
    d_write = ~dw;
    d_stb = ~ds;
    step;
    for (int i = 0; i < waits; i++) begin
      pready = 1'b0; perr = ew;
      chk("wait_psel", psel, 1);
      chk("wait_penable", penable, 1);
      chk("wait_paddr", paddr, ea);
      chk("wait_done", f_done | d_done, 0);
      step;
    end
    pready = 1'b1; prdata = rd; perr = er;
    chk("acc_psel", psel, 1);
    chk("acc_penable", penable, 1);
    chk("acc_paddr", paddr, ea);
    chk("acc_pdata", pdata, ed);
    chk("acc_pwrite", pwrite, ewr);
    chk("acc_pstb", pstb, es);
    step;
    pready = 1'b0; perr = 1'b0; prdata = $urandom;
    if (wd_) begin md_rd = rd; md_err = er; end
    else begin mf_rd = rd; mf_err = er; end
    chk("done_f", f_done, !wd_);
    chk("done_d", d_done, wd_);
    chk("done_frdata", f_rdata, mf_rd);
    chk("done_drdata", d_rdata, md_rd);
    chk("done_ferr", f_err, mf_err);
    chk("done_derr", d_err, md_err);
    chk("done_psel", psel, 0);
    chk("done_penable", penable, 0);
    if (!keep) begin f_req = 1'b0; d_req = 1'b0; end
    step;
    chk_bus_idle("idle");
  endtask

  initial begin
    bit fr, dr;
    step;
    step;
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_pwrite", pwrite, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_pdata", pdata, 0);
    chk("rst_pstb", pstb, 0);
    chk("rst_done", {f_done, d_done}, 0);
    chk("rst_err", {f_err, d_err}, 0);
    chk("rst_frdata", f_rdata, 0);
    chk("rst_drdata", d_rdata, 0);
    rst = 1'b0;
    step;

    xfer(0, 1, 32'h0, 32'h10, 32'hDEADBEEF, 1, 4'hF, 0, 32'h0, 0, 0, 0);
    xfer(1, 0, 32'h20, 32'h0, 32'h0, 0, 4'h0, 3, 32'h12345678, 0, 0, 0);
    xfer(0, 1, 32'h0, 32'h400, 32'h0, 0, 4'hF, 1, 32'hA5A5, 1, 0, 0);
    xfer(0, 1, 32'h0, 32'h400, 32'h0, 0, 4'hF, 2, 32'h5A5A, 0, 1, 0);
    xfer(0, 1, 32'h0, 32'h40, 32'h77, 1, 4'h3, 1, 32'h0, 0, 0, 0);

    d_req = 1'b1; d_addr = 32'h30; d_write = 1'b0;
    step;
    step;
    pready = 1'b0;
    chk("midrst_penable_pre", penable, 1);
    rst = 1'b1;
    step;
    chk_bus_idle("midrst");
    chk("midrst_drdata", d_rdata, 0);
    rst = 1'b0; d_req = 1'b0;
    last_data = 1'b0;
    mf_rd = '0; md_rd = '0; mf_err = 1'b0; md_err = 1'b0;
    step;
    chk_bus_idle("midrst_after");

    xfer(1, 1, 32'h100, 32'h200, 32'h1, 1, 4'hF, 0, 32'h11, 0, 0, 1);
    xfer(1, 1, 32'h100, 32'h200, 32'h2, 1, 4'hF, 0, 32'h22, 0, 0, 1);
    xfer(1, 1, 32'h100, 32'h200, 32'h3, 1, 4'hF, 0, 32'h33, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      fr = 1'($urandom);
      dr = 1'($urandom);
      if (!fr && !dr) dr = 1'b1;
      xfer(fr, dr, $urandom, $urandom, $urandom, 1'($urandom),
           4'($urandom), int'($urandom_range(0, 3)), $urandom,
           1'($urandom), 1'($urandom), 0);
    end

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
